// File: rtl/solitaire_pkg.sv
// solitaire_pkg: constants and types shared by the peg-solitaire engine and
// the greedy autoplayer.
//   BOARD_WIDTH        board side length
//   LEFT/RIGHT/UP/DOWN direction encoding on the engine's direction input
//   state_t            autoplayer FSM states
//   PARK_*             move presented while not driving (always illegal)
package solitaire_pkg;

  localparam int BOARD_WIDTH = 7;

  localparam logic [1:0] LEFT  = 2'd0;
  localparam logic [1:0] RIGHT = 2'd1;
  localparam logic [1:0] UP    = 2'd2;
  localparam logic [1:0] DOWN  = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    CHECK = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] PARK_X   = 3'd0;
  localparam logic [2:0] PARK_Y   = 3'd0;
  localparam logic [1:0] PARK_DIR = LEFT;

endpackage

// File: rtl/solitaire_cand_counter.sv
// solitaire_cand_counter: nested candidate-move counter. dir increments
// fastest, then x, then y; everything wraps back to zero after (W-1,W-1,DOWN).
//   clk, rst_n   clock, async active-low reset
//   clear        return to candidate 0 (priority over advance)
//   advance      step to the next candidate
//   x, y, dir    current candidate
//   last         current candidate is the final one of a scan
module solitaire_cand_counter #(
  parameter int BOARD_WIDTH = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       advance,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [1:0] dir,
  output logic       last
);
  import solitaire_pkg::*;

  localparam logic [2:0] MAX_COORD = 3'(BOARD_WIDTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= 3'd0;
      y   <= 3'd0;
      dir <= LEFT;
    end else if (clear) begin
      x   <= 3'd0;
      y   <= 3'd0;
      dir <= LEFT;
    end else if (advance) begin
      if (dir != DOWN) begin
        dir <= dir + 2'd1;
      end else begin
        dir <= LEFT;
        if (x != MAX_COORD) begin
          x <= x + 3'd1;
        end else begin
          x <= 3'd0;
          y <= (y == MAX_COORD) ? 3'd0 : y + 3'd1;
        end
      end
    end
  end

  assign last = (x == MAX_COORD) && (y == MAX_COORD) && (dir == DOWN);

endmodule

// File: rtl/solitaire_autoplayer.sv
// solitaire_autoplayer: greedy move generator for the peg-solitaire engine.
// Scans every (x, y, dir) candidate in order, detects acceptance by a
// piece_count decrement one cycle after presenting it, logs accepted moves.
//   clk, rst_n                  clock, async active-low reset (shared with engine)
//   start, step_mode            play control
//   piece_count, game_over      from the engine
//   piece_x, piece_y, direction candidate move to the engine (park unless DRIVE)
//   busy                        in DRIVE, CHECK or WAIT
//   move_accepted               one-cycle pulse per accepted move
//   last_x, last_y, last_dir    most recently accepted move
//   moves_made                  accepted move count (saturating)
//   done, stuck                 play finished / finished with no move found
//
// state | meaning
// IDLE  | waiting for start
// DRIVE | candidate presented to the engine
// CHECK | compare piece_count against the value captured in DRIVE
// WAIT  | step mode pause after an accepted move
// DONE  | terminal until reset
module solitaire_autoplayer #(
  parameter int BOARD_WIDTH = solitaire_pkg::BOARD_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       step_mode,
  input  logic [5:0] piece_count,
  input  logic       game_over,
  output logic [2:0] piece_x,
  output logic [2:0] piece_y,
  output logic [1:0] direction,
  output logic       busy,
  output logic       move_accepted,
  output logic [2:0] last_x,
  output logic [2:0] last_y,
  output logic [1:0] last_dir,
  output logic [5:0] moves_made,
  output logic       done,
  output logic       stuck
);
  import solitaire_pkg::*;

  state_t     state;
  logic [5:0] cnt_q;
  logic [2:0] chk_x, chk_y;
  logic [1:0] chk_dir;
  logic       scan_end;
  logic [2:0] cand_x, cand_y;
  logic [1:0] cand_dir;
  logic       cand_last;
  logic       accepted;

  // The counter steps on the DRIVE cycle, so by CHECK it already points at
  // the following candidate; the move under test is kept in chk_*.
  solitaire_cand_counter #(.BOARD_WIDTH(BOARD_WIDTH)) u_cand (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == CHECK && accepted),
    .advance (state == DRIVE),
    .x       (cand_x),
    .y       (cand_y),
    .dir     (cand_dir),
    .last    (cand_last)
  );

  assign accepted = (piece_count == cnt_q - 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      piece_x       <= PARK_X;
      piece_y       <= PARK_Y;
      direction     <= PARK_DIR;
      busy          <= 1'b0;
      move_accepted <= 1'b0;
      last_x        <= 3'd0;
      last_y        <= 3'd0;
      last_dir      <= 2'd0;
      moves_made    <= 6'd0;
      done          <= 1'b0;
      stuck         <= 1'b0;
      cnt_q         <= 6'd0;
      chk_x         <= 3'd0;
      chk_y         <= 3'd0;
      chk_dir       <= 2'd0;
      scan_end      <= 1'b0;
    end else begin
      move_accepted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (game_over) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= DRIVE;
              busy      <= 1'b1;
              piece_x   <= cand_x;
              piece_y   <= cand_y;
              direction <= cand_dir;
            end
          end
        end
        DRIVE: begin
          state     <= CHECK;
          cnt_q     <= piece_count;
          chk_x     <= piece_x;
          chk_y     <= piece_y;
          chk_dir   <= direction;
          scan_end  <= cand_last;
          piece_x   <= PARK_X;
          piece_y   <= PARK_Y;
          direction <= PARK_DIR;
        end
        CHECK: begin
          if (accepted) begin
            move_accepted <= 1'b1;
            last_x        <= chk_x;
            last_y        <= chk_y;
            last_dir      <= chk_dir;
            if (moves_made != 6'd63) moves_made <= moves_made + 6'd1;
            if (game_over) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (step_mode) begin
              state <= WAIT;
            end else begin
              // Rescan from candidate 0; the counter is being cleared this edge.
              state     <= DRIVE;
              piece_x   <= 3'd0;
              piece_y   <= 3'd0;
              direction <= LEFT;
            end
          end else if (scan_end) begin
            state <= DONE;
            done  <= 1'b1;
            stuck <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state     <= DRIVE;
            piece_x   <= cand_x;
            piece_y   <= cand_y;
            direction <= cand_dir;
          end
        end
        WAIT: begin
          if (start) begin
            state     <= DRIVE;
            piece_x   <= cand_x;
            piece_y   <= cand_y;
            direction <= cand_dir;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solitaire_autoplayer.sv
module tb_solitaire_autoplayer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       step_mode;
  logic [5:0] piece_count;
  logic       game_over;
  logic [2:0] piece_x, piece_y;
  logic [1:0] direction;
  logic       busy, move_accepted;
  logic [2:0] last_x, last_y;
  logic [1:0] last_dir;
  logic [5:0] moves_made;
  logic       done, stuck;

  int vectors = 0;
  int miscompares = 0;

  logic       go_mask = 1'b0;
  logic       go_high = 1'b0;
  logic [48:0] board;
  logic       eng_go;

  always #5 clk = ~clk;

  solitaire_autoplayer #(.BOARD_WIDTH(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .step_mode    (step_mode),
    .piece_count  (piece_count),
    .game_over    (game_over),
    .piece_x      (piece_x),
    .piece_y      (piece_y),
    .direction    (direction),
    .busy         (busy),
    .move_accepted(move_accepted),
    .last_x       (last_x),
    .last_y       (last_y),
    .last_dir     (last_dir),
    .moves_made   (moves_made),
    .done         (done),
    .stuck        (stuck)
  );

  // ---------------- behavioural peg-solitaire engine ----------------
  function automatic bit on_board(int x, int y);
    return x >= 0 && x < 7 && y >= 0 && y < 7 &&
           ((x >= 2 && x <= 4) || (y >= 2 && y <= 4));
  endfunction

  function automatic bit has_peg(logic [48:0] b, int x, int y);
    if (!on_board(x, y)) return 1'b0;
    return b[y*7+x];
  endfunction

  function automatic bit legal(logic [48:0] b, int x, int y, int d);
    int dx, dy;
    dx = 0; dy = 0;
    case (d)
      0: dx = -1;
      1: dx = 1;
      2: dy = -1;
      default: dy = 1;
    endcase
    return has_peg(b, x, y) && has_peg(b, x+dx, y+dy) &&
           on_board(x+2*dx, y+2*dy) && !has_peg(b, x+2*dx, y+2*dy);
  endfunction

  function automatic logic [48:0] apply_move(logic [48:0] b, int x, int y, int d);
    logic [48:0] nb;
    int dx, dy;
    dx = 0; dy = 0;
    case (d)
      0: dx = -1;
      1: dx = 1;
      2: dy = -1;
      default: dy = 1;
    endcase
    nb = b;
    nb[y*7+x] = 1'b0;
    nb[(y+dy)*7+x+dx] = 1'b0;
    nb[(y+2*dy)*7+x+2*dx] = 1'b1;
    return nb;
  endfunction

  function automatic logic [48:0] init_board();
    logic [48:0] b;
    b = '0;
    for (int y = 0; y < 7; y++)
      for (int x = 0; x < 7; x++)
        if (on_board(x, y) && !(x == 3 && y == 3)) b[y*7+x] = 1'b1;
    return b;
  endfunction

  function automatic bit any_legal(logic [48:0] b);
    for (int y = 0; y < 7; y++)
      for (int x = 0; x < 7; x++)
        for (int d = 0; d < 4; d++)
          if (legal(b, x, y, d)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) board <= init_board();
    else if (legal(board, int'(piece_x), int'(piece_y), int'(direction)))
      board <= apply_move(board, int'(piece_x), int'(piece_y), int'(direction));
  end

  assign piece_count = 6'($countones(board));

  always_comb begin
    eng_go    = !any_legal(board);
    game_over = go_high | (eng_go & ~go_mask);
  end

  // ---------------- stimulus helpers ----------------
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [27:0] outs;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs = {piece_x, piece_y, direction, busy, move_accepted, last_x, last_y,
            last_dir, moves_made, done, stuck};
    vectors++;
    if (outs !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_during outputs got %h exp 0", outs);
    end
    vectors++;
    if (piece_count !== 6'd32) begin
      miscompares++;
      $display("FAIL reset_engine piece_count got %0d exp 32", piece_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    adv(2);
    outs = {piece_x, piece_y, direction, busy, move_accepted, last_x, last_y,
            last_dir, moves_made, done, stuck};
    vectors++;
    if (outs !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_after outputs got %h exp 0", outs);
    end
  endtask

  // Expects IDLE with a fresh board, at a falling edge.
  task automatic test_first_move(input bit hold_start);
    start = 1'b1;
    adv(1);                                        // edge 0
    vectors++;
    if (busy !== 1'b1 || {piece_x, piece_y, direction} !== 8'd0) begin
      miscompares++;
      $display("FAIL first_edge0 busy/move got %b/%h exp 1/00", busy,
               {piece_x, piece_y, direction});
    end
    if (!hold_start) start = 1'b0;
    adv(2);                                        // edge 2: candidate 1
    vectors++;
    if ({piece_x, piece_y, direction} !== {3'd0, 3'd0, 2'd1}) begin
      miscompares++;
      $display("FAIL first_cand1 move got %h exp %h",
               {piece_x, piece_y, direction}, {3'd0, 3'd0, 2'd1});
    end
    adv(84);                                       // edge 86: candidate 43
    vectors++;
    if ({piece_x, piece_y, direction} !== {3'd3, 3'd1, 2'd3}) begin
      miscompares++;
      $display("FAIL first_cand43 move got %h exp %h",
               {piece_x, piece_y, direction}, {3'd3, 3'd1, 2'd3});
    end
    adv(1);                                        // edge 87: engine applied
    vectors++;
    if (piece_count !== 6'd31 || move_accepted !== 1'b0) begin
      miscompares++;
      $display("FAIL first_edge87 count/pulse got %0d/%b exp 31/0",
               piece_count, move_accepted);
    end
    adv(1);                                        // edge 88
    vectors++;
    if (move_accepted !== 1'b1 || {last_x, last_y, last_dir} !== {3'd3, 3'd1, 2'd3} ||
        moves_made !== 6'd1) begin
      miscompares++;
      $display("FAIL first_edge88 pulse/last/moves got %b/%h/%0d exp 1/%h/1",
               move_accepted, {last_x, last_y, last_dir}, moves_made,
               {3'd3, 3'd1, 2'd3});
    end
    adv(1);                                        // edge 89
    vectors++;
    if (move_accepted !== 1'b0 || moves_made !== 6'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL first_edge89 pulse/moves/busy got %b/%0d/%b exp 0/1/1",
               move_accepted, moves_made, busy);
    end
    start = 1'b0;
  endtask

  task automatic test_step_mode();
    do_reset();
    step_mode = 1'b1;
    start = 1'b1;
    adv(1);
    start = 1'b0;
    adv(88);                                       // edge 88
    vectors++;
    if (move_accepted !== 1'b1 || moves_made !== 6'd1) begin
      miscompares++;
      $display("FAIL step_first pulse/moves got %b/%0d exp 1/1",
               move_accepted, moves_made);
    end
    adv(51);                                       // parked in WAIT
    vectors++;
    if (busy !== 1'b1 || {piece_x, piece_y, direction} !== 8'd0 ||
        moves_made !== 6'd1 || piece_count !== 6'd31 || move_accepted !== 1'b0) begin
      miscompares++;
      $display("FAIL step_wait busy/move/moves/count got %b/%h/%0d/%0d exp 1/00/1/31",
               busy, {piece_x, piece_y, direction}, moves_made, piece_count);
    end
    start = 1'b1;
    adv(1);                                        // edge w
    start = 1'b0;
    adv(2);                                        // w+2: candidate 1
    vectors++;
    if ({piece_x, piece_y, direction} !== {3'd0, 3'd0, 2'd1}) begin
      miscompares++;
      $display("FAIL step_resume move got %h exp %h",
               {piece_x, piece_y, direction}, {3'd0, 3'd0, 2'd1});
    end
    adv(121);                                      // w+123
    vectors++;
    if (move_accepted !== 1'b0) begin
      miscompares++;
      $display("FAIL step_early pulse got %b exp 0", move_accepted);
    end
    adv(1);                                        // w+124: candidate 61
    vectors++;
    if (move_accepted !== 1'b1 || {last_x, last_y, last_dir} !== {3'd1, 3'd2, 2'd1} ||
        moves_made !== 6'd2 || piece_count !== 6'd30) begin
      miscompares++;
      $display("FAIL step_second pulse/last/moves/count got %b/%h/%0d/%0d exp 1/%h/2/30",
               move_accepted, {last_x, last_y, last_dir}, moves_made, piece_count,
               {3'd1, 3'd2, 2'd1});
    end
    step_mode = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [27:0] outs;
    do_reset();
    start = 1'b1;
    adv(1);
    start = 1'b0;
    adv(39);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_busy_before got %b exp 1", busy);
    end
    @(posedge clk);                                // edge 40
    #1 rst_n = 1'b0;
    #1;
    outs = {piece_x, piece_y, direction, busy, move_accepted, last_x, last_y,
            last_dir, moves_made, done, stuck};
    vectors++;
    if (outs !== 28'd0 || piece_count !== 6'd32) begin
      miscompares++;
      $display("FAIL midrst_outputs got %h/%0d exp 0/32", outs, piece_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_first_move(1'b0);
  endtask

  task automatic test_full_run(input bit mask, output int decs_out);
    int e, last_pulse, decs, perr;
    logic dec_prev, dec_now;
    logic [5:0] pc_prev;
    do_reset();
    go_mask = mask;
    start = 1'b1;
    adv(1);
    start = 1'b0;
    e = 0; last_pulse = -1; decs = 0; perr = 0;
    dec_prev = 1'b0;
    pc_prev = piece_count;
    while (done !== 1'b1 && e < 20000) begin
      adv(1);
      e++;
      if (move_accepted !== dec_prev) perr++;
      if (move_accepted === 1'b1) last_pulse = e;
      dec_now = (piece_count !== pc_prev);
      if (dec_now) decs++;
      dec_prev = dec_now;
      pc_prev = piece_count;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL run%0d_timeout done got %b exp 1", mask, done);
    end
    vectors++;
    if (perr !== 0) begin
      miscompares++;
      $display("FAIL run%0d_pulse_vs_decrement got %0d bad cycles exp 0", mask, perr);
    end
    vectors++;
    if (busy !== 1'b0 || moves_made !== 6'(decs) ||
        32'(moves_made) + 32'(piece_count) !== 32) begin
      miscompares++;
      $display("FAIL run%0d_totals busy/moves/count got %b/%0d/%0d exp 0/%0d/%0d",
               mask, busy, moves_made, piece_count, decs, 32 - decs);
    end
    vectors++;
    if (stuck !== !game_over || stuck !== mask) begin
      miscompares++;
      $display("FAIL run%0d_stuck got %b (game_over %b) exp %b", mask, stuck,
               game_over, mask);
    end
    vectors++;
    if (e - last_pulse !== (mask ? 392 : 0)) begin
      miscompares++;
      $display("FAIL run%0d_done_timing got %0d edges after last move exp %0d",
               mask, e - last_pulse, mask ? 392 : 0);
    end
    go_mask = 1'b0;
    decs_out = decs;
  endtask

  task automatic test_start_in_done(input int decs);
    start = 1'b1;
    adv(5);
    start = 1'b0;
    adv(2);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || stuck !== 1'b0 || move_accepted !== 1'b0 ||
        {piece_x, piece_y, direction} !== 8'd0 || moves_made !== 6'(decs) ||
        piece_count !== 6'(32 - decs)) begin
      miscompares++;
      $display("FAIL done_start done/busy/stuck/pulse/move/moves/count got %b/%b/%b/%b/%h/%0d/%0d exp 1/0/0/0/00/%0d/%0d",
               done, busy, stuck, move_accepted, {piece_x, piece_y, direction},
               moves_made, piece_count, decs, 32 - decs);
    end
  endtask

  task automatic test_idle_done();
    do_reset();
    go_high = 1'b1;
    start = 1'b1;
    adv(1);
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || stuck !== 1'b0 || busy !== 1'b0 || moves_made !== 6'd0 ||
        {piece_x, piece_y, direction} !== 8'd0) begin
      miscompares++;
      $display("FAIL idle_done done/stuck/busy/moves/move got %b/%b/%b/%0d/%h exp 1/0/0/0/00",
               done, stuck, busy, moves_made, {piece_x, piece_y, direction});
    end
    go_high = 1'b0;
    adv(3);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || piece_count !== 6'd32) begin
      miscompares++;
      $display("FAIL idle_done_hold done/busy/count got %b/%b/%0d exp 1/0/32",
               done, busy, piece_count);
    end
  endtask

  initial begin
    int decs;
    rst_n = 1'b0;
    start = 1'b0;
    step_mode = 1'b0;
    test_reset();
    test_first_move(1'b0);
    do_reset();
    test_first_move(1'b1);
    test_step_mode();
    test_mid_reset();
    test_full_run(1'b0, decs);
    test_start_in_done(decs);
    test_full_run(1'b1, decs);
    test_idle_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
